// File: rtl/clock_disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clock_disp_pkg
//  Description : Shared constants, output bundle type and segment decoder
//                for the alarm-clock seven-segment display.
//  Revision    : 1.0 - initial release
// ============================================================================
package clock_disp_pkg;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [5:0] HH_MAX = 6'd23;
    localparam logic [5:0] MM_MAX = 6'd59;

    localparam logic [1:0] DIG_HT = 2'd3;
    localparam logic [1:0] DIG_HU = 2'd2;
    localparam logic [1:0] DIG_MT = 2'd1;
    localparam logic [1:0] DIG_MU = 2'd0;

    typedef struct packed {
        logic [3:0] anode;
        logic [6:0] seg;
        logic       dp;
    } disp_out_t;

    localparam disp_out_t DISP_OFF = '{anode: 4'b1111, seg: SEG_BLANK, dp: 1'b1};

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'd0:    pat = SEG_DIGIT[0];
            4'd1:    pat = SEG_DIGIT[1];
            4'd2:    pat = SEG_DIGIT[2];
            4'd3:    pat = SEG_DIGIT[3];
            4'd4:    pat = SEG_DIGIT[4];
            4'd5:    pat = SEG_DIGIT[5];
            4'd6:    pat = SEG_DIGIT[6];
            4'd7:    pat = SEG_DIGIT[7];
            4'd8:    pat = SEG_DIGIT[8];
            4'd9:    pat = SEG_DIGIT[9];
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/separator.sv
`default_nettype none
// ============================================================================
//  Module      : separator
//  Description : Splits a 0..63 binary value into decimal tens and units.
//  Revision    : 1.0 - initial release
// ============================================================================
module separator (
    input  logic [5:0] value_i,
    output logic [3:0] tens_o,
    output logic [3:0] units_o
);

    logic [5:0] w_base;

    always_comb begin
        tens_o = 4'd0;
        w_base = 6'd0;
        if (value_i >= 6'd60) begin
            tens_o = 4'd6;
            w_base = 6'd60;
        end else if (value_i >= 6'd50) begin
            tens_o = 4'd5;
            w_base = 6'd50;
        end else if (value_i >= 6'd40) begin
            tens_o = 4'd4;
            w_base = 6'd40;
        end else if (value_i >= 6'd30) begin
            tens_o = 4'd3;
            w_base = 6'd30;
        end else if (value_i >= 6'd20) begin
            tens_o = 4'd2;
            w_base = 6'd20;
        end else if (value_i >= 6'd10) begin
            tens_o = 4'd1;
            w_base = 6'd10;
        end
        units_o = 4'(value_i - w_base);
    end

endmodule
`default_nettype wire

// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : display_scan_ctrl
//  Description : Four-digit multiplexed seven-segment scan controller with
//                per-frame snapshot, range dashes, blink and colon point.
//  Revision    : 1.0 - initial release
// ============================================================================
module display_scan_ctrl
    import clock_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] time_hh,
    input  logic [5:0] time_mm,
    input  logic [5:0] alarm_hh,
    input  logic [5:0] alarm_mm,
    input  logic       show_alarm,
    input  logic [3:0] blink_mask,
    input  logic       colon_on,
    output logic [3:0] anode,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         dig_q, dig_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_ph_q, blink_ph_d;
    logic [5:0]         hh_q, hh_d;
    logic [5:0]         mm_q, mm_d;
    disp_out_t          out_q, out_d;

    logic       w_cnt_wrap;
    logic       w_blink_wrap;
    logic       w_snap;
    logic [5:0] w_sep_in;
    logic [3:0] w_tens;
    logic [3:0] w_units;
    logic [3:0] w_nibble;
    logic       w_dash;
    logic       w_blank;
    logic       w_blinked;
    logic [6:0] w_pattern;

    separator u_separator (
        .value_i (w_sep_in),
        .tens_o  (w_tens),
        .units_o (w_units)
    );

    always_comb begin
        w_cnt_wrap   = (cnt_q == CNT_W'(REFRESH_DIV - 1));
        w_blink_wrap = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));
        cnt_d        = w_cnt_wrap ? '0 : cnt_q + CNT_W'(1);
        dig_d        = w_cnt_wrap ? dig_q - 2'd1 : dig_q;
        blink_cnt_d  = w_blink_wrap ? '0 : blink_cnt_q + BLINK_W'(1);
        blink_ph_d   = blink_ph_q ^ w_blink_wrap;

        // Whole frame shows one coherent value pair, latched at its start.
        w_snap = (cnt_q == '0) && (dig_q == DIG_HT);
        hh_d   = hh_q;
        mm_d   = mm_q;
        if (w_snap) begin
            hh_d = show_alarm ? alarm_hh : time_hh;
            mm_d = show_alarm ? alarm_mm : time_mm;
        end
    end

    always_comb begin
        w_sep_in  = dig_q[1] ? hh_q : mm_q;
        w_nibble  = dig_q[0] ? w_tens : w_units;
        w_dash    = dig_q[1] ? (hh_q > HH_MAX) : (mm_q > MM_MAX);
        w_pattern = w_dash ? SEG_DASH : seg_decode(w_nibble);
        w_blank   = (cnt_q == '0);
        w_blinked = blink_ph_q && blink_mask[dig_q];

        out_d       = DISP_OFF;
        out_d.anode = (w_blank || w_blinked) ? 4'b1111 : ~(4'b0001 << dig_q);
        out_d.seg   = w_blank ? SEG_BLANK : w_pattern;
        out_d.dp    = !((dig_q == DIG_HU) && colon_on && !w_blank && !w_blinked);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            dig_q       <= DIG_HT;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            hh_q        <= '0;
            mm_q        <= '0;
            out_q       <= DISP_OFF;
        end else begin
            cnt_q       <= cnt_d;
            dig_q       <= dig_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            hh_q        <= hh_d;
            mm_q        <= mm_d;
            out_q       <= out_d;
        end
    end

    assign anode = out_q.anode;
    assign seg   = out_q.seg;
    assign dp    = out_q.dp;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_scan_ctrl
//  Description : Randomised self-checking bench for display_scan_ctrl against
//                an arithmetic frame/slot model of the display.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scan_ctrl;

    localparam int R = 4;
    localparam int B = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] time_hh = 6'd12;
    logic [5:0] time_mm = 6'd34;
    logic [5:0] alarm_hh = 6'd0;
    logic [5:0] alarm_mm = 6'd0;
    logic       show_alarm = 1'b0;
    logic [3:0] blink_mask = 4'b0000;
    logic       colon_on = 1'b1;
    logic [3:0] anode;
    logic [6:0] seg;
    logic       dp;

    int n_checks = 0;
    int n_fail   = 0;
    int n_print  = 0;

    always #5 clk = ~clk;

    display_scan_ctrl #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
        .clk        (clk),
        .rst        (rst),
        .time_hh    (time_hh),
        .time_mm    (time_mm),
        .alarm_hh   (alarm_hh),
        .alarm_mm   (alarm_mm),
        .show_alarm (show_alarm),
        .blink_mask (blink_mask),
        .colon_on   (colon_on),
        .anode      (anode),
        .seg        (seg),
        .dp         (dp)
    );

    function automatic logic [6:0] pat(input int v);
        case (v)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic report(input string name, input int act, input int exp);
        n_fail++;
        if (n_print < 30) begin
            n_print++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) report(name, act, exp);
    endtask

    // Model: k counts non-reset cycles since reset; slot, digit and blink
    // phase follow directly from k by division.
    int         k = 0;
    logic       m_valid = 1'b0;
    int         m_hh = 0;
    int         m_mm = 0;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_blk;

    always @(posedge clk) begin
        int   cnt, d, ph, v, dv;
        logic bad;
        if (rst) begin
            k = 0; m_valid = 1'b1;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_blk = 1'b0;
        end else if (m_valid) begin
            cnt = k % R;
            d   = 3 - ((k / R) % 4);
            ph  = (k / B) % 2;
            v   = (d >= 2) ? m_hh : m_mm;
            bad = (d >= 2) ? (m_hh > 23) : (m_mm > 59);
            dv  = (d % 2 == 1) ? v / 10 : v % 10;
            e_blk = (ph == 1) && blink_mask[d];
            e_an  = (cnt == 0 || e_blk) ? 4'hF : ~(4'b0001 << d);
            e_seg = (cnt == 0) ? 7'h7F : (bad ? 7'h3F : pat(dv));
            e_dp  = (d == 2 && colon_on && cnt != 0 && !e_blk) ? 1'b0 : 1'b1;
            if (k % (4 * R) == 0) begin
                m_hh = show_alarm ? int'(alarm_hh) : int'(time_hh);
                m_mm = show_alarm ? int'(alarm_mm) : int'(time_mm);
            end
            k++;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_anode", int'(anode), int'(e_an));
            if (!e_blk) begin
                chk("model_seg", int'(seg), int'(e_seg));
                chk("model_dp", int'(dp), int'(e_dp));
            end
        end
    end

    task automatic wait_an(input logic [3:0] t, input int budget);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (anode === t) found = 1'b1;
        end
        if (!found) begin
            n_checks++;
            report("wait_anode_timeout", int'(anode), int'(t));
        end
    endtask

    initial begin
        // Reset hold and first frame
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_anode", int'(anode), 'hF);
        chk("rst_seg", int'(seg), 'h7F);
        chk("rst_dp", int'(dp), 1);
        @(negedge clk);
        chk("first_blank_anode", int'(anode), 'hF);
        chk("first_blank_seg", int'(seg), 'h7F);
        @(negedge clk);
        chk("d3_anode", int'(anode), 'b0111);
        chk("d3_seg_1", int'(seg), 'h79);
        repeat (3) @(negedge clk);
        chk("slot2_blank", int'(anode), 'hF);
        @(negedge clk);
        chk("d2_anode", int'(anode), 'b1011);
        chk("d2_seg_2", int'(seg), 'h24);
        chk("d2_colon", int'(dp), 0);
        wait_an(4'b1101, 20);
        chk("d1_seg_3", int'(seg), 'h30);

        // Snapshot integrity
        wait_an(4'b1011, 40);
        time_mm = 6'd35;
        wait_an(4'b1110, 40);
        chk("snap_old_4", int'(seg), 'h19);
        wait_an(4'b0111, 40);
        wait_an(4'b1110, 40);
        chk("snap_new_5", int'(seg), 'h12);
        alarm_hh = 6'd7;
        alarm_mm = 6'd8;
        wait_an(4'b1101, 40);
        show_alarm = 1'b1;
        wait_an(4'b1110, 40);
        chk("alarm_late_5", int'(seg), 'h12);
        wait_an(4'b0111, 40);
        chk("alarm_h_0", int'(seg), 'h40);
        wait_an(4'b1110, 40);
        chk("alarm_m_8", int'(seg), 'h00);

        // Range clamp
        alarm_hh = 6'd24;
        alarm_mm = 6'd60;
        wait_an(4'b0111, 40);
        chk("dash_d3", int'(seg), 'h3F);
        wait_an(4'b1011, 40);
        chk("dash_d2", int'(seg), 'h3F);
        wait_an(4'b1110, 40);
        chk("dash_d0", int'(seg), 'h3F);

        // Blink on minutes
        show_alarm = 1'b0;
        blink_mask = 4'b0011;
        repeat (140) @(negedge clk);

        // Randomised inputs
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if ($urandom_range(7) == 0) begin
                case ($urandom_range(6))
                    0: time_hh    = 6'($urandom_range(31));
                    1: time_mm    = 6'($urandom_range(63));
                    2: alarm_hh   = 6'($urandom_range(31));
                    3: alarm_mm   = 6'($urandom_range(63));
                    4: show_alarm = 1'($urandom_range(1));
                    5: blink_mask = 4'($urandom_range(15));
                    default: colon_on = 1'($urandom_range(1));
                endcase
            end
        end

        // Reset mid-frame
        blink_mask = 4'b0000;
        show_alarm = 1'b0;
        time_hh    = 6'd9;
        time_mm    = 6'd5;
        colon_on   = 1'b1;
        wait_an(4'b1101, 40);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_anode", int'(anode), 'hF);
        chk("midrst_dp", int'(dp), 1);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_blank", int'(anode), 'hF);
        @(negedge clk);
        chk("midrst_d3", int'(anode), 'b0111);
        chk("midrst_d3_seg_0", int'(seg), 'h40);
        wait_an(4'b1011, 20);
        chk("midrst_d2_seg_9", int'(seg), 'h10);
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexed four-digit seven-segment display controller for the alarm clock. It snapshots the hours and minutes to show, either current time or alarm, once per scan frame. It shares a single `separator` instance across all four digits to produce tens and units, and drives active-low anodes and segments with inter-digit blanking, per-digit blink and a colon point. It sits between the timekeeping/alarm registers and the board display pins.

## Interface
- `REFRESH_DIV`, 100000: clock cycles per digit slot. Must be ≥2.
- `BLINK_DIV`, 50000000: clock cycles per blink half-period.
- `clk` in 1: system clock. All logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `time_hh` in 6: current hours, valid range 0..23.
- `time_mm` in 6: current minutes, valid range 0..59.
- `alarm_hh` in 6: alarm hours, valid range 0..23.
- `alarm_mm` in 6: alarm minutes, valid range 0..59.
- `show_alarm` in 1: 1 selects the alarm values, 0 selects the time values.
- `blink_mask` in 4: bit i=1 makes digit i blink. Digit 3 is leftmost (hours tens).
- `colon_on` in 1: lights the decimal point on digit 2.
- `anode` out 4: digit enables, active low.
- `seg` out 7: segments {g,f,e,d,c,b,a}, active low.
- `dp` out 1: decimal point, active low.

## Operation
- **State registers and reset values:**
  - `cnt`: 0..REFRESH_DIV-1, reset 0.
  - `dig`: 2-bit, reset 3.
  - `blink_cnt`: reset 0.
  - `blink_ph`: reset 0.
  - `hh_q`, `mm_q`: reset 0.
- **Refresh counter:** `cnt` increments every cycle and wraps to 0 after REFRESH_DIV-1.
- **Digit pointer:** on each `cnt` wrap, `dig` steps 3→2→1→0→3.
- **Blink timer:** `blink_cnt` wraps after BLINK_DIV-1. On each wrap, `blink_ph` toggles.
- **Snapshot:** in the cycle where `cnt`==0 and `dig`==3, load `hh_q`/`mm_q` from the alarm or time pair selected by `show_alarm`.
  - This cycle includes the first cycle after reset.
  - Inputs and `show_alarm` are sampled only at the snapshot. Changes mid-frame never tear the display.
- **Separator arbitration:**
  - Separator input = `dig[1]` ? `hh_q` : `mm_q`.
  - Digits 3 and 1 use `tens`. Digits 2 and 0 use `units`.
- **Range check:**
  - If `hh_q` > 23, digits 3 and 2 show a dash (seg=7'b0111111).
  - If `mm_q` > 59, digits 1 and 0 show a dash.
- **Decode:** 0..9 map to standard active-low patterns. Any other nibble decodes to blank (7'h7F).
- **Blank slot:** when `cnt`==0, drive `anode`=4'b1111, `seg`=7'h7F, `dp`=1. This is anti-ghosting blanking.
- **Blink:** when `blink_ph`==1 and `blink_mask[dig]`==1, `anode`=4'b1111 for the whole slot.
- **Colon:** `dp`=0 only when `dig`==2, `colon_on`==1 and the slot is not blanked. Otherwise `dp`=1.
- **Active digit:** otherwise, `anode` = one-cold at bit `dig`.

## Timing
- **Registered outputs:** the outputs in cycle N+1 are a function of `cnt`, `dig`, `blink_ph`, `hh_q`, `mm_q`, `blink_mask` and `colon_on` in cycle N.
- **During reset:** while `rst` is high, and in the first cycle after release, `anode`=4'b1111, `seg`=7'h7F, `dp`=1.
- **Latency:** snapshot input to first lit digit is 2 cycles. The snapshot cycle has `cnt`=0, so the next output is the blank slot; the following output shows digit 3.
- **Slot shape:** each slot is 1 blank cycle followed by REFRESH_DIV-1 lit cycles. A full frame is 4×REFRESH_DIV cycles.
- **Reset mid-frame:** `rst` asserted in any cycle gives all-off outputs in the next cycle. The controller restarts from digit 3 with a fresh snapshot.
- **Simultaneous events:** a `blink_ph` toggle coinciding with a slot change takes effect on the new slot at the same registered edge. No special ordering applies.

## Structure
- **Shared package `clock_disp_pkg`:**
  - SEG_DIGIT[0:9] patterns, SEG_DASH, SEG_BLANK.
  - HH_MAX=23 and MM_MAX=59.
  - Digit index constants DIG_HT=3, DIG_HU=2, DIG_MT=1, DIG_MU=0.
- **Sub-module:** one instance of the existing `separator`. Segment decode is a package function, not a separate module.
- **Counter widths:** `$clog2` of each divider.

## Test plan
All scenarios use REFRESH_DIV=4 and BLINK_DIV=32.
- **Reset hold:** hold `rst` for 3 cycles, then release. `anode`=1111, `seg`=7F and `dp`=1 through reset and 1 cycle after. Digit 3 is lit from the 2nd cycle after release.
- **Normal scan:** `time_hh`=12, `time_mm`=34, `show_alarm`=0, `colon_on`=1. Slots show anode 0111 seg "1", then 1011 "2" with dp=0, then 1101 "3", then 1110 "4". Each slot is 1 blank cycle then 3 lit cycles, and the sequence repeats.
- **Snapshot integrity:** change `time_mm` 34→35 during the digit-2 slot. Digit 0 still shows "4" this frame and "5" next frame. Toggling `show_alarm` mid-frame also takes effect only at the next frame.
- **Range clamp:** `alarm_hh`=24, `alarm_mm`=60, `show_alarm`=1. All four digits show SEG_DASH (7'b0111111).
- **Blink:** `blink_mask`=0011. While `blink_ph`=1 (32 cycles), digits 1 and 0 have `anode`=1111 and digits 3 and 2 are lit normally. While `blink_ph`=0, all four digits are lit.
- **Reset mid-frame:** pulse `rst` for 1 cycle during the digit-1 slot. Outputs are all-off next cycle. The scan restarts at digit 3 with `cnt`=0 and a new snapshot.
